// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction fetch sequencer.
// Used by fetch_sequencer and fetch_pc_unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ISSUE = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } fetch_state_t;

    localparam logic [5:0] OPC_CTRL = 6'b111111;
    localparam logic [5:0] OPC_JUMP = 6'b101010;

    localparam logic [1:0] CTRL_END   = 2'b00;
    localparam logic [1:0] CTRL_RSVD  = 2'b01;
    localparam logic [1:0] CTRL_START = 2'b10;
    localparam logic [1:0] CTRL_STOP  = 2'b11;

    localparam int CTRL_SIG_WIDTH = 19;

    // Control sub-codes that keep fetching sequentially after the control word
    function automatic logic ctrl_advances(input logic [1:0] sub_code);
        return (sub_code == CTRL_START) || (sub_code == CTRL_RSVD);
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter register: load from start/jump target or step by PC_STEP.
// Wraps modulo 2^ADDR_WIDTH.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + ADDR_WIDTH'(PC_STEP);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC ownership, memory req/ack, issue to decode, control/jump handling.
// Optional FETCH_PERF_CNT_EN adds issued/stall performance counters.
//
// state | meaning
// IDLE  | stopped after reset or end control word; waits for start_in
// REQ   | mem_req_out held at PC until mem_ack_in
// ISSUE | instruction held on ins_out until decode accepts
// FLUSH | after a jump word; waits for jump_in or timer expiry
// HALT  | stopped by stop control word; waits for start_in
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int PC_STEP    = 4,
    parameter int JUMP_WAIT  = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start_in,
    input  logic [ADDR_WIDTH-1:0]     start_addr_in,
    output logic                      mem_req_out,
    output logic [ADDR_WIDTH-1:0]     mem_addr_out,
    input  logic                      mem_ack_in,
    input  logic [BUS_WIDTH-1:0]      mem_data_in,
    output logic                      ins_valid_out,
    output logic [BUS_WIDTH-1:0]      ins_out,
    input  logic                      ins_ready_in,
    input  logic                      jump_in,
    input  logic [ADDR_WIDTH-1:0]     jump_addr_in,
    output logic                      ctrl_valid_out,
    output logic [CTRL_SIG_WIDTH-1:0] ctrl_signal_out,
    output logic                      halted_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]               issued_cnt_out,
    output logic [31:0]               stall_cnt_out,
`endif
    output logic                      busy_out
);

    localparam int TIMER_WIDTH = (JUMP_WAIT > 1) ? $clog2(JUMP_WAIT) : 1;

    fetch_state_t            state_q;
    fetch_state_t            state_d;
    logic [TIMER_WIDTH-1:0]  timer_q;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    pc_load;
    logic [ADDR_WIDTH-1:0]   pc_load_addr;
    logic                    pc_inc;

    logic [5:0] mem_opcode;
    logic [1:0] mem_sub_code;
    logic [5:0] ins_opcode;
    logic       mem_take;
    logic       mem_is_ctrl;
    logic       issue_take;

    assign mem_opcode   = mem_data_in[BUS_WIDTH-1 -: 6];
    assign mem_sub_code = mem_data_in[25:24];
    assign ins_opcode   = ins_out[BUS_WIDTH-1 -: 6];
    assign mem_take     = (state_q == REQ) && mem_ack_in;
    assign mem_is_ctrl  = (mem_opcode == OPC_CTRL);
    assign issue_take   = (state_q == ISSUE) && ins_ready_in;

    fetch_pc_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PC_STEP    (PC_STEP)
    ) u_pc (
        .clock     (clock),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (pc_load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_in) state_d = REQ;
            end
            REQ: begin
                if (mem_ack_in) begin
                    if (mem_is_ctrl) begin
                        case (mem_sub_code)
                            CTRL_STOP: state_d = HALT;
                            CTRL_END:  state_d = IDLE;
                            default:   state_d = REQ;
                        endcase
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ins_ready_in) state_d = (ins_opcode == OPC_JUMP) ? FLUSH : REQ;
            end
            FLUSH: begin
                // jump_in on the expiry cycle also lands here, with the jump target loaded
                if (jump_in || (timer_q == '0)) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_out   = (state_q == REQ);
        ins_valid_out = (state_q == ISSUE);
        halted_out    = (state_q == HALT);
        busy_out      = (state_q != IDLE) && (state_q != HALT);
        pc_load       = (((state_q == IDLE) || (state_q == HALT)) && start_in)
                        || ((state_q == FLUSH) && jump_in);
        pc_load_addr  = (state_q == FLUSH) ? jump_addr_in : start_addr_in;
        pc_inc        = (mem_take && mem_is_ctrl && ctrl_advances(mem_sub_code)) || issue_take;
    end

    assign mem_addr_out = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ins_out         <= '0;
            ctrl_signal_out <= '0;
            ctrl_valid_out  <= 1'b0;
        end else begin
            ctrl_valid_out <= 1'b0;
            if (mem_take) begin
                if (mem_is_ctrl) begin
                    ctrl_signal_out <= mem_data_in[25:7];
                    ctrl_valid_out  <= (mem_sub_code != CTRL_RSVD);
                end else begin
                    ins_out <= mem_data_in;
                end
            end
        end
    end

    // Down-counter preloaded outside FLUSH so FLUSH lasts exactly JUMP_WAIT cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state_q != FLUSH) begin
            timer_q <= TIMER_WIDTH'(JUMP_WAIT - 1);
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic perf_clear;
    logic stall_cycle;

    assign perf_clear  = ((state_q == IDLE) || (state_q == HALT)) && start_in;
    assign stall_cycle = ((state_q == REQ) && !mem_ack_in) || ((state_q == ISSUE) && !ins_ready_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_cnt_out <= '0;
            stall_cnt_out  <= '0;
        end else if (perf_clear) begin
            issued_cnt_out <= '0;
            stall_cnt_out  <= '0;
        end else begin
            if (issue_take && (issued_cnt_out != '1)) issued_cnt_out <= issued_cnt_out + 1'b1;
            if (stall_cycle && (stall_cnt_out != '1)) stall_cnt_out <= stall_cnt_out + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected requests,
// issued words and control pulses; a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        start_in;
    logic [15:0] start_addr_in;
    logic        mem_req_out;
    logic [15:0] mem_addr_out;
    logic        mem_ack_in;
    logic [31:0] mem_data_in;
    logic        ins_valid_out;
    logic [31:0] ins_out;
    logic        ins_ready_in;
    logic        jump_in;
    logic [15:0] jump_addr_in;
    logic        ctrl_valid_out;
    logic [18:0] ctrl_signal_out;
    logic        halted_out;
    logic        busy_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_cnt_out;
    logic [31:0] stall_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_req_q[$];
    logic [31:0] exp_ins_q[$];
    logic [18:0] exp_ctrl_q[$];

    fetch_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .start_in        (start_in),
        .start_addr_in   (start_addr_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .mem_ack_in      (mem_ack_in),
        .mem_data_in     (mem_data_in),
        .ins_valid_out   (ins_valid_out),
        .ins_out         (ins_out),
        .ins_ready_in    (ins_ready_in),
        .jump_in         (jump_in),
        .jump_addr_in    (jump_addr_in),
        .ctrl_valid_out  (ctrl_valid_out),
        .ctrl_signal_out (ctrl_signal_out),
        .halted_out      (halted_out),
`ifdef FETCH_PERF_CNT_EN
        .issued_cnt_out  (issued_cnt_out),
        .stall_cnt_out   (stall_cnt_out),
`endif
        .busy_out        (busy_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares every new request, issue handshake and control pulse
    initial begin : monitor
        logic        prev_pending;
        logic [31:0] exp_v;
        prev_pending = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_pending = 1'b0;
            end else begin
                if (mem_req_out && !prev_pending) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_req", {16'h0, mem_addr_out}, 32'hFFFF_FFFF);
                    end else begin
                        exp_v = {16'h0, exp_req_q.pop_front()};
                        check("req_addr", {16'h0, mem_addr_out}, exp_v);
                    end
                end
                prev_pending = mem_req_out && !mem_ack_in;
                if (ins_valid_out && ins_ready_in) begin
                    if (exp_ins_q.size() == 0) begin
                        check("unexpected_ins", ins_out, 32'hDEAD_BEEF);
                    end else begin
                        exp_v = exp_ins_q.pop_front();
                        check("ins_word", ins_out, exp_v);
                    end
                end
                if (ctrl_valid_out) begin
                    if (exp_ctrl_q.size() == 0) begin
                        check("unexpected_ctrl", {13'h0, ctrl_signal_out}, 32'hFFFF_FFFF);
                    end else begin
                        exp_v = {13'h0, exp_ctrl_q.pop_front()};
                        check("ctrl_signal", {13'h0, ctrl_signal_out}, exp_v);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset         = 1'b1;
        start_in      = 1'b0;
        start_addr_in = '0;
        mem_ack_in    = 1'b0;
        mem_data_in   = '0;
        ins_ready_in  = 1'b1;
        jump_in       = 1'b0;
        jump_addr_in  = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_req",       {31'h0, mem_req_out},    32'h0);
        check("rst_valid",     {31'h0, ins_valid_out},  32'h0);
        check("rst_ins",       ins_out,                 32'h0);
        check("rst_ctrl",      {13'h0, ctrl_signal_out}, 32'h0);
        check("rst_halted",    {31'h0, halted_out},     32'h0);
        check("rst_busy",      {31'h0, busy_out},       32'h0);
        check("rst_addr",      {16'h0, mem_addr_out},   32'h0);
        reset = 1'b0;
        step();

        // Normal fetch from 0x0100, ack immediately, ready high
        exp_req_q.push_back(16'h0100);
        start_in = 1'b1; start_addr_in = 16'h0100;
        step();
        start_in = 1'b0;
        check("start_latency_req", {31'h0, mem_req_out}, 32'h1);
        mem_ack_in = 1'b1; mem_data_in = 32'h0000_0001;
        exp_ins_q.push_back(32'h0000_0001);
        exp_req_q.push_back(16'h0104);
        step();
        mem_ack_in = 1'b0;
        check("ack_latency_valid", {31'h0, ins_valid_out}, 32'h1);
        step();
        check("next_req_addr", {16'h0, mem_addr_out}, 32'h0104);

        // Decode stalls for 3 cycles
        ins_ready_in = 1'b0;
        mem_ack_in = 1'b1; mem_data_in = 32'h0000_0002;
        exp_ins_q.push_back(32'h0000_0002);
        step();
        mem_ack_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'h0, ins_valid_out}, 32'h1);
            check("stall_ins",   ins_out,                32'h0000_0002);
            check("stall_pc",    {16'h0, mem_addr_out},  32'h0104);
            step();
        end
        ins_ready_in = 1'b1;
        exp_req_q.push_back(16'h0108);
        step();
        check("post_stall_addr", {16'h0, mem_addr_out}, 32'h0108);

        // Jump word, target supplied two cycles after acceptance
        mem_ack_in = 1'b1; mem_data_in = 32'hA800_0000;
        exp_ins_q.push_back(32'hA800_0000);
        step();
        mem_ack_in = 1'b0;
        step();
        check("flush_no_req", {31'h0, mem_req_out}, 32'h0);
        jump_in = 1'b1; jump_addr_in = 16'h0200;
        exp_req_q.push_back(16'h0200);
        step();
        jump_in = 1'b0;
        check("jump_req",  {31'h0, mem_req_out},  32'h1);
        check("jump_addr", {16'h0, mem_addr_out}, 32'h0200);

        // jump_in while in REQ has no effect
        jump_in = 1'b1; jump_addr_in = 16'h3000;
        step();
        jump_in = 1'b0;
        check("jump_ignored", {16'h0, mem_addr_out}, 32'h0200);

        // Jump word with no target: timeout after JUMP_WAIT cycles
        mem_ack_in = 1'b1; mem_data_in = 32'hA800_0000;
        exp_ins_q.push_back(32'hA800_0000);
        step();
        mem_ack_in = 1'b0;
        step();
        check("timeout_c1_req", {31'h0, mem_req_out}, 32'h0);
        mem_ack_in = 1'b1; mem_data_in = 32'hFF00_0000;
        step();
        mem_ack_in = 1'b0;
        check("timeout_c2_req", {31'h0, mem_req_out}, 32'h0);
        exp_req_q.push_back(16'h0204);
        step();
        check("timeout_c3_req", {31'h0, mem_req_out}, 32'h0);
        step();
        check("timeout_req",  {31'h0, mem_req_out},  32'h1);
        check("timeout_addr", {16'h0, mem_addr_out}, 32'h0204);

        // Control start word continues at PC+4 with a pulse
        mem_ack_in = 1'b1; mem_data_in = 32'hFE00_0080;
        exp_ctrl_q.push_back(19'h40001);
        exp_req_q.push_back(16'h0208);
        step();
        mem_ack_in = 1'b0;
        check("ctrl_start_pulse", {31'h0, ctrl_valid_out}, 32'h1);
        check("ctrl_start_addr",  {16'h0, mem_addr_out},   32'h0208);
        step();
        check("ctrl_pulse_width", {31'h0, ctrl_valid_out}, 32'h0);

        // Reserved sub-code: advance without pulse
        mem_ack_in = 1'b1; mem_data_in = 32'hFD00_0000;
        exp_req_q.push_back(16'h020C);
        step();
        mem_ack_in = 1'b0;
        check("rsvd_no_pulse", {31'h0, ctrl_valid_out}, 32'h0);
        check("rsvd_addr",     {16'h0, mem_addr_out},   32'h020C);

        // Stop word halts
        mem_ack_in = 1'b1; mem_data_in = 32'hFF00_0000;
        exp_ctrl_q.push_back(19'h60000);
        step();
        mem_ack_in = 1'b0;
        check("stop_pulse",  {31'h0, ctrl_valid_out}, 32'h1);
        check("stop_halted", {31'h0, halted_out},     32'h1);
        check("stop_busy",   {31'h0, busy_out},       32'h0);
        check("stop_no_req", {31'h0, mem_req_out},    32'h0);
        step();
        check("halt_no_req", {31'h0, mem_req_out},    32'h0);

        // Restart from HALT
        exp_req_q.push_back(16'h0040);
        start_in = 1'b1; start_addr_in = 16'h0040;
        step();
        start_in = 1'b0;
        check("restart_addr",   {16'h0, mem_addr_out}, 32'h0040);
        check("restart_halted", {31'h0, halted_out},   32'h0);

        // start_in in REQ is ignored
        start_in = 1'b1; start_addr_in = 16'h0500;
        step();
        start_in = 1'b0;
        check("start_ignored", {16'h0, mem_addr_out}, 32'h0040);

        // End word returns to IDLE
        mem_ack_in = 1'b1; mem_data_in = 32'hFC00_0000;
        exp_ctrl_q.push_back(19'h00000);
        step();
        mem_ack_in = 1'b0;
        check("end_busy",   {31'h0, busy_out},   32'h0);
        check("end_halted", {31'h0, halted_out}, 32'h0);
        check("end_req",    {31'h0, mem_req_out}, 32'h0);

        // PC wrap at top of address space
        exp_req_q.push_back(16'hFFFC);
        start_in = 1'b1; start_addr_in = 16'hFFFC;
        step();
        start_in = 1'b0;
        mem_ack_in = 1'b1; mem_data_in = 32'h0000_0003;
        exp_ins_q.push_back(32'h0000_0003);
        exp_req_q.push_back(16'h0000);
        step();
        mem_ack_in = 1'b0;
        step();
        check("wrap_req",  {31'h0, mem_req_out},  32'h1);
        check("wrap_addr", {16'h0, mem_addr_out}, 32'h0000);

        // Async reset while requesting
        step();
        reset = 1'b1;
        #1;
        check("async_rst_req",   {31'h0, mem_req_out},   32'h0);
        check("async_rst_busy",  {31'h0, busy_out},      32'h0);
        check("async_rst_valid", {31'h0, ins_valid_out}, 32'h0);
        step();
        reset = 1'b0;
        step();
        step();
        check("post_rst_idle_req", {31'h0, mem_req_out}, 32'h0);

        check("left_req",  exp_req_q.size(),  32'd0);
        check("left_ins",  exp_ins_q.size(),  32'd0);
        check("left_ctrl", exp_ctrl_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
